// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one 4x4 unsigned multiplier.
// Define MULT_ARB_PERF_EN to add the op_count / op_count_clr counter.
module mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_product,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
`ifdef MULT_ARB_PERF_EN
  ,
  output logic [15:0]          op_count,
  input  logic                 op_count_clr
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] idx;
  logic [ID_W-1:0] id;
  logic            any_req;
  logic            grant_hs;
  logic [3:0]      op_a;
  logic [3:0]      op_b;
  logic [7:0]      prod;

  // First asserted requester at or after rr_ptr, wrapping.
  always_comb begin
    win     = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!any_req && req_valid[idx]) begin
        win     = idx;
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = CALC;
      CALC:    state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant is gated by rst_n so req_ready reads 0 while reset is held.
  always_comb begin
    req_ready = '0;
    grant_hs  = 1'b0;
    busy      = (state != IDLE);
    if (state == IDLE && any_req && rst_n) begin
      req_ready[win] = 1'b1;
      grant_hs       = 1'b1;
    end
  end

  assign prod = {4'b0, op_a} * {4'b0, op_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      op_a        <= '0;
      op_b        <= '0;
      id          <= '0;
      rsp_valid   <= 1'b0;
      rsp_product <= '0;
      rsp_id      <= '0;
    end else begin
      if (grant_hs) begin
        op_a   <= req_a[4*win +: 4];
        op_b   <= req_b[4*win +: 4];
        id     <= win;
        rr_ptr <= (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
      end
      if (state == CALC) begin
        rsp_product <= prod;
        rsp_id      <= id;
        rsp_valid   <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef MULT_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      op_count <= '0;
    else if (op_count_clr)
      op_count <= '0;
    else if (rsp_valid && rsp_ready)
      op_count <= op_count + 16'd1;
  end
`endif

endmodule
